data_mem_port: RTL
==================

# data_mem_port

Word-addressed data-memory port directly downstream of the core's load/store unit. It serves one 32-bit access per cycle at the address the load/store unit presents, so a 4-word vector transfer streams as four back-to-back accesses with no wait states. Each address goes to either a local RAM array or a small memory-mapped register window: cycle counter, store counter, scratch register and fault status. Read data is combinational so it is usable in the same cycle; writes commit on the clock edge.

## Interface
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two.
- MMIO_BASE, 32'h0001_0000: byte base of the 16-byte register window.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_addr  in  32  byte address from the load/store unit.
- mem_we  in  1  write strobe for the current cycle's access.
- mem_wdata  in  32  store data, valid when mem_we=1.
- mem_readdata  out  32  combinational read data for mem_addr.
- fault  out  1  sticky; 1 after any illegal access since reset or clear.
- fault_addr  out  32  address of the first illegal access.

## Operation
- Address decode, all combinational on mem_addr:
  - RAM hit: mem_addr < 4*DEPTH_WORDS; index = mem_addr[$clog2(DEPTH_WORDS)+1:2].
  - MMIO hit: MMIO_BASE ≤ mem_addr < MMIO_BASE+16; register offset = mem_addr[3:2].
  - Illegal: misaligned (mem_addr[1:0] != 0) or neither region. Misalignment wins over a region hit.
- MMIO registers:
  - 0x0 CYCLES: read-only; increments every non-reset cycle; wraps 2^32-1 → 0.
  - 0x4 SCRATCH: read/write.
  - 0x8 STATUS: bit0 = fault. Writing 1 to bit0 clears fault and fault_addr; other bits read 0.
  - 0xC STORES: read-only; counts committed legal writes (RAM or SCRATCH/STATUS); wraps.
  - Writes to 0x0 and 0xC are legal but ignored; they do not increment STORES.
- Read path: mem_readdata shows RAM[index], the selected register, or 0 for an illegal access. It is driven regardless of mem_we.
- Write path: on a legal write, RAM/register updates at the edge. An illegal write changes no data.
- Fault capture:
  - When an illegal access occurs and fault=0, fault←1 and fault_addr←mem_addr.
  - Later illegal accesses leave fault_addr unchanged.
  - If a STATUS clear and an illegal access happen in the same cycle, that cannot occur from the same access. Clear is evaluated first, so the next illegal access recaptures.
- No handshake. The port is always ready, and every cycle is an access, so the idle address must be legal (the load/store unit holds its base address).

## Timing
- Read latency 0 cycles (combinational, same cycle as mem_addr).
- Read-during-write to the same word returns the old value; the new value is visible the next cycle.
- Back-to-back accesses: full rate, one per cycle, no bubbles; consecutive vector addresses A, A+4, A+8, A+12 read in 4 cycles.
- Reset (reset=0 at an edge):
  - CYCLES, SCRATCH, STORES, fault and fault_addr all go to 0.
  - RAM contents are not cleared.
  - A write asserted during reset is dropped.
  - Reset asserted mid-vector-burst drops the remaining beats; already-committed words stay.
- CYCLES is 0 in the first cycle after reset deasserts, and 1 in the next.
- STORES increments at the same edge as the write it counts.

## Structure
- Shared package mem_map_pkg: MMIO_BASE default, register offsets (OFF_CYCLES, OFF_SCRATCH, OFF_STATUS, OFF_STORES), and typedef enum region_t {REG_RAM, REG_MMIO, REG_ILLEGAL}.
- One sub-module, mmio_regs: the four registers plus fault capture. It takes decoded offset, we, wdata and illegal; it returns rdata, fault and fault_addr.
- The RAM array and decode stay in the top module.

## Test plan
- Reset then idle at addr 0: CYCLES read at MMIO_BASE shows 0, 1, 2 on consecutive cycles; fault=0, fault_addr=0.
- Vector store 0x11,0x22,0x33,0x44 to 0x40..0x4C on 4 consecutive cycles, then read back → 0x11,0x22,0x33,0x44 with no stalls; STORES=4.
- Write 0xDEAD to 0x80 while reading 0x80 in the same cycle → old value that cycle, 0xDEAD next cycle.
- Read 0x42 (misaligned) → mem_readdata=0, fault=1, fault_addr=0x42. Then write at 0xFFFF_0000 → fault_addr stays 0x42 and RAM is unchanged.
- Write 1 to MMIO_BASE+8 → fault=0, fault_addr=0. Write 0x5A to SCRATCH → reads 0x5A. Write to CYCLES → ignored and STORES not incremented.
- Assert reset after beat 2 of a 4-beat vector store → beats 1-2 present in RAM, beats 3-4 absent; all registers 0.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the data-memory port: MMIO window base,
// register offsets within the window, and the address-decode region type.
package mem_map_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0001_0000;
  localparam logic [31:0] MMIO_SPAN         = 32'd16;

  localparam logic [1:0] OFF_CYCLES  = 2'd0;
  localparam logic [1:0] OFF_SCRATCH = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_STORES  = 2'd3;

  typedef enum logic [1:0] {
    REG_RAM     = 2'd0,
    REG_MMIO    = 2'd1,
    REG_ILLEGAL = 2'd2
  } region_t;

endpackage

// File: rtl/mmio_regs.sv
// Memory-mapped register window: free-running cycle counter, scratch
// register, sticky fault status with first-address capture, and a counter
// of committed legal stores (RAM or writable registers).
module mmio_regs
  import mem_map_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  offset,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] addr,
  input  logic        illegal,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [31:0] fault_addr
);

  logic [31:0] cycles;
  logic [31:0] scratch;
  logic [31:0] stores;
  logic        clr;
  logic        scratch_we;
  logic        count_store;

  // Decode the write side effects; `we` is already qualified as a legal write,
  // so a write with sel=0 is a RAM store.
  always_comb begin
    clr         = we && sel && (offset == OFF_STATUS) && wdata[0];
    scratch_we  = we && sel && (offset == OFF_SCRATCH);
    count_store = we && (!sel || (offset == OFF_SCRATCH) || (offset == OFF_STATUS));
  end

  // Register state; a STATUS clear takes priority so the next illegal access recaptures.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycles     <= '0;
      scratch    <= '0;
      stores     <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (scratch_we)  scratch <= wdata;
      if (count_store) stores  <= stores + 32'd1;
      if (clr) begin
        fault      <= 1'b0;
        fault_addr <= '0;
      end else if (illegal && !fault) begin
        fault      <= 1'b1;
        fault_addr <= addr;
      end
    end
  end

  // Combinational register read mux.
  always_comb begin
    rdata = '0;
    unique case (offset)
      OFF_CYCLES:  rdata = cycles;
      OFF_SCRATCH: rdata = scratch;
      OFF_STATUS:  rdata = {31'd0, fault};
      OFF_STORES:  rdata = stores;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_port.sv
// Word-addressed data-memory port behind the load/store unit. One access per
// cycle, combinational read data, writes commit at the clock edge. Addresses
// decode to the local RAM, the MMIO register window, or an illegal access.
module data_mem_port
  import mem_map_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_we,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_readdata,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [31:0] ram [DEPTH_WORDS];

  region_t     region;
  logic [AW-1:0] index;
  logic [31:0] mmio_off;
  logic        ram_hit;
  logic        mmio_hit;
  logic        misaligned;
  logic        illegal;
  logic        legal_we;
  logic        ram_we;
  logic [31:0] mmio_rdata;

  // Address decode; misalignment overrides any region hit.
  always_comb begin
    mmio_off   = mem_addr - MMIO_BASE;
    ram_hit    = {1'b0, mem_addr} < RAM_LIMIT;
    mmio_hit   = mmio_off < MMIO_SPAN;
    misaligned = mem_addr[1:0] != 2'b00;
    index      = mem_addr[AW+1:2];
    if (misaligned)    region = REG_ILLEGAL;
    else if (ram_hit)  region = REG_RAM;
    else if (mmio_hit) region = REG_MMIO;
    else               region = REG_ILLEGAL;
    illegal  = region == REG_ILLEGAL;
    legal_we = mem_we && !illegal;
    ram_we   = legal_we && (region == REG_RAM) && reset;
  end

  // RAM write port; contents survive reset, writes during reset are dropped.
  always_ff @(posedge clk) begin
    if (ram_we) ram[index] <= mem_wdata;
  end

  mmio_regs u_mmio_regs (
    .clk        (clk),
    .reset      (reset),
    .sel        (region == REG_MMIO),
    .offset     (mem_addr[3:2]),
    .we         (legal_we),
    .wdata      (mem_wdata),
    .addr       (mem_addr),
    .illegal    (illegal),
    .rdata      (mmio_rdata),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  // Read data mux: RAM word, register, or zero for an illegal access.
  always_comb begin
    mem_readdata = '0;
    unique case (region)
      REG_RAM:  mem_readdata = ram[index];
      REG_MMIO: mem_readdata = mmio_rdata;
      default:  mem_readdata = '0;
    endcase
  end

endmodule
